// File: rtl/mastermind_pkg.sv
// Shared Mastermind constants, feedback codes and scorer state encoding.
package mastermind_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int COLOR_W   = 3;
    localparam int ROW_W     = NUM_SLOTS * COLOR_W;
    localparam int FB_W      = 2 * NUM_SLOTS;
    localparam int IDX_W     = 2;
    localparam int CNT_W     = 3;

    localparam logic [COLOR_W-1:0] COLOR_EMPTY = '0;
    localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(NUM_SLOTS - 1);

    localparam logic [1:0] FB_NONE    = 2'b00;
    localparam logic [1:0] FB_PRESENT = 2'b01;
    localparam logic [1:0] FB_EXACT   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXACT,
        ST_PARTIAL,
        ST_DONE
    } state_e;

    function automatic logic [COLOR_W-1:0] get_color(
        input logic [ROW_W-1:0] row,
        input int               k
    );
        return row[k*COLOR_W +: COLOR_W];
    endfunction

endpackage

// File: rtl/mastermind_slot_search.sv
// Combinational lowest-index finder of an unconsumed answer slot of a colour.
module mastermind_slot_search
    import mastermind_pkg::*;
(
    input  logic [COLOR_W-1:0]   color,
    input  logic [ROW_W-1:0]     answer,
    input  logic [NUM_SLOTS-1:0] consumed,
    output logic                 found,
    output logic [IDX_W-1:0]     j
);

    always_comb begin
        found = 1'b0;
        j     = '0;
        // Scan downward so the lowest matching index wins.
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (!consumed[k] && color != COLOR_EMPTY &&
                get_color(answer, k) == color) begin
                found = 1'b1;
                j     = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/mastermind_scorer.sv
// Sequential Mastermind scorer: exact pass then present pass, one slot per cycle.
module mastermind_scorer
    import mastermind_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [ROW_W-1:0] guess,
    input  logic [ROW_W-1:0] answer,
    output logic             busy,
    output logic             done,
    output logic [FB_W-1:0]  feedback,
    output logic [CNT_W-1:0] exact_cnt,
    output logic [CNT_W-1:0] present_cnt,
    output logic             win
);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [ROW_W-1:0]     g_q, g_d;
    logic [ROW_W-1:0]     a_q, a_d;
    logic [NUM_SLOTS-1:0] consumed_q, consumed_d;
    logic [FB_W-1:0]      fb_w_q, fb_w_d;
    logic [CNT_W-1:0]     ex_w_q, ex_w_d;
    logic [CNT_W-1:0]     pr_w_q, pr_w_d;
    logic [FB_W-1:0]      fb_out_q, fb_out_d;
    logic [CNT_W-1:0]     ex_out_q, ex_out_d;
    logic [CNT_W-1:0]     pr_out_q, pr_out_d;
    logic                 win_q, win_d;

    logic [COLOR_W-1:0]   cur_g;
    logic [COLOR_W-1:0]   cur_a;
    logic [1:0]           cur_fb;
    logic                 hit;
    logic [IDX_W-1:0]     hit_j;

    assign cur_g  = get_color(g_q, int'(idx_q));
    assign cur_a  = get_color(a_q, int'(idx_q));
    assign cur_fb = fb_w_q[2*int'(idx_q) +: 2];

    mastermind_slot_search u_search (
        .color    (cur_g),
        .answer   (a_q),
        .consumed (consumed_q),
        .found    (hit),
        .j        (hit_j)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        g_d        = g_q;
        a_d        = a_q;
        consumed_d = consumed_q;
        fb_w_d     = fb_w_q;
        ex_w_d     = ex_w_q;
        pr_w_d     = pr_w_q;
        fb_out_d   = fb_out_q;
        ex_out_d   = ex_out_q;
        pr_out_d   = pr_out_q;
        win_d      = win_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    g_d        = guess;
                    a_d        = answer;
                    idx_d      = '0;
                    consumed_d = '0;
                    fb_w_d     = '0;
                    ex_w_d     = '0;
                    pr_w_d     = '0;
                    state_d    = ST_EXACT;
                end
            end
            ST_EXACT: begin
                if (cur_g == cur_a && cur_g != COLOR_EMPTY) begin
                    fb_w_d[2*int'(idx_q) +: 2] = FB_EXACT;
                    consumed_d[idx_q]          = 1'b1;
                    ex_w_d                     = ex_w_q + 3'd1;
                end
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = ST_PARTIAL;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_PARTIAL: begin
                if (cur_fb != FB_EXACT && cur_g != COLOR_EMPTY && hit) begin
                    fb_w_d[2*int'(idx_q) +: 2] = FB_PRESENT;
                    consumed_d[hit_j]          = 1'b1;
                    pr_w_d                     = pr_w_q + 3'd1;
                end
                if (idx_q == IDX_LAST) begin
                    // Publish on the final edge so results are valid with done.
                    fb_out_d = fb_w_d;
                    ex_out_d = ex_w_q;
                    pr_out_d = pr_w_d;
                    win_d    = (ex_w_q == CNT_W'(NUM_SLOTS));
                    state_d  = ST_DONE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            g_q        <= '0;
            a_q        <= '0;
            consumed_q <= '0;
            fb_w_q     <= '0;
            ex_w_q     <= '0;
            pr_w_q     <= '0;
            fb_out_q   <= '0;
            ex_out_q   <= '0;
            pr_out_q   <= '0;
            win_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            g_q        <= g_d;
            a_q        <= a_d;
            consumed_q <= consumed_d;
            fb_w_q     <= fb_w_d;
            ex_w_q     <= ex_w_d;
            pr_w_q     <= pr_w_d;
            fb_out_q   <= fb_out_d;
            ex_out_q   <= ex_out_d;
            pr_out_q   <= pr_out_d;
            win_q      <= win_d;
        end
    end

    assign busy        = (state_q == ST_EXACT) || (state_q == ST_PARTIAL);
    assign done        = (state_q == ST_DONE);
    assign feedback    = fb_out_q;
    assign exact_cnt   = ex_out_q;
    assign present_cnt = pr_out_q;
    assign win         = win_q;

endmodule

// File: tb/tb_mastermind_scorer.sv
// Scoreboard bench for mastermind_scorer using directed, hand-scored vectors.
module tb_mastermind_scorer;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic [11:0] guess;
    logic [11:0] answer;
    logic        busy;
    logic        done;
    logic [7:0]  feedback;
    logic [2:0]  exact_cnt;
    logic [2:0]  present_cnt;
    logic        win;

    typedef struct packed {
        logic [7:0] fb;
        logic [2:0] ex;
        logic [2:0] pr;
        logic       win;
    } exp_t;

    exp_t q[$];
    int   total;
    int   bad;
    int   done_seen;
    int   runs;
    logic [7:0] prev_fb;

    mastermind_scorer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .start       (start),
        .guess       (guess),
        .answer      (answer),
        .busy        (busy),
        .done        (done),
        .feedback    (feedback),
        .exact_cnt   (exact_cnt),
        .present_cnt (present_cnt),
        .win         (win)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every done pulse against the scoreboard head.
    always @(negedge Clk) begin
        if (Reset && done) begin
            exp_t e;
            done_seen++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done got=1 want=0");
            end else begin
                e = q.pop_front();
                chk("feedback", 32'(feedback), 32'(e.fb));
                chk("exact_cnt", 32'(exact_cnt), 32'(e.ex));
                chk("present_cnt", 32'(present_cnt), 32'(e.pr));
                chk("win", 32'(win), 32'(e.win));
            end
        end
    end

    task automatic run(input logic [11:0] g, input logic [11:0] a,
                       input logic [7:0] efb, input logic [2:0] eex,
                       input logic [2:0] epr, input logic ew,
                       input bit interfere);
        exp_t e;
        bit   seen;
        e = '{fb: efb, ex: eex, pr: epr, win: ew};
        q.push_back(e);
        runs++;
        guess  = g;
        answer = a;
        start  = 1'b1;
        @(posedge Clk);
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge Clk);
            if (k == 1) begin
                start = 1'b0;
                chk("busy_after_start", 32'(busy), 32'd1);
                chk("persist_fb", 32'(feedback), 32'(prev_fb));
            end
            if (interfere && k == 2) begin
                guess  = 12'b001_001_001_001;
                answer = 12'b001_001_001_001;
            end
            if (interfere && k == 3) start = 1'b1;
            if (interfere && k == 4) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                chk("latency", 32'(k), 32'd9);
                chk("busy_in_done", 32'(busy), 32'd0);
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout got=0 want=1");
        end
        prev_fb = efb;
        @(negedge Clk);
    endtask

    task automatic run_abort(input logic [11:0] g, input logic [11:0] a);
        guess  = g;
        answer = a;
        start  = 1'b1;
        @(posedge Clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge Clk);
            if (k == 1) start = 1'b0;
            if (k == 4) Reset = 1'b0;
            if (k == 5) begin
                chk("abort_feedback", 32'(feedback), 32'd0);
                chk("abort_exact", 32'(exact_cnt), 32'd0);
                chk("abort_present", 32'(present_cnt), 32'd0);
                chk("abort_win", 32'(win), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                Reset = 1'b1;
            end
        end
        prev_fb = 8'h00;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        done_seen = 0;
        runs      = 0;
        prev_fb   = 8'h00;
        Reset     = 1'b0;
        start     = 1'b0;
        guess     = '0;
        answer    = '0;
        repeat (3) @(negedge Clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_feedback", 32'(feedback), 32'd0);
        chk("rst_counts", 32'({exact_cnt, present_cnt}), 32'd0);
        chk("rst_win", 32'(win), 32'd0);
        Reset = 1'b1;
        @(negedge Clk);

        run(12'b001_001_001_001, 12'b001_001_001_001,
            8'b10_10_10_10, 3'd4, 3'd0, 1'b1, 1'b0);
        run(12'b001_010_011_100, 12'b100_011_010_001,
            8'b01_01_01_01, 3'd0, 3'd4, 1'b0, 1'b1);
        run(12'b001_001_001_001, 12'b011_010_001_001,
            8'b00_00_10_10, 3'd2, 3'd0, 1'b0, 1'b0);
        run(12'b001_001_010_100, 12'b010_010_001_011,
            8'b00_01_01_00, 3'd0, 3'd2, 1'b0, 1'b0);
        run(12'b000_000_000_000, 12'b001_010_011_100,
            8'b00_00_00_00, 3'd0, 3'd0, 1'b0, 1'b0);
        run(12'b101_011_110_010, 12'b101_110_011_010,
            8'b10_01_01_10, 3'd2, 3'd2, 1'b0, 1'b0);
        run_abort(12'b001_001_001_001, 12'b001_001_001_001);
        run(12'b101_011_110_010, 12'b101_110_011_010,
            8'b10_01_01_10, 3'd2, 3'd2, 1'b0, 1'b0);

        repeat (12) @(negedge Clk);
        chk("done_count", 32'(done_seen), 32'(runs));
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
